atom_cfg_loader: RTL and testbench

//  Upstream configuration stage for the stateful subtract/add atom. Accepts config words over a

---
 rtl/atom_cfg_loader.sv | 152 +++++++++++++++
 tb/tb_atom_cfg_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/atom_cfg_loader.sv
// Double-buffered configuration loader for the subtract/add atom: shadow bank filled over valid/ready,
// swapped into the active bank on a packet bubble. Optional readback port: ATOM_CFG_READBACK_EN.
module atom_cfg_loader #(
   parameter int DATA_W  = 32,
   parameter int N_WORDS = 6,
   parameter int GEN_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i__cfg_valid,
   output logic              o__cfg_ready,
   input  logic [2:0]        i__cfg_addr,
   input  logic [DATA_W-1:0] i__cfg_data,
   input  logic              i__commit,
   input  logic              i__pkt_valid,
   output logic [DATA_W-1:0] o__cons_1,
   output logic [DATA_W-1:0] o__cons_2,
   output logic [DATA_W-1:0] o__cons_3,
   output logic [DATA_W-1:0] o__cons_4,
   output logic [DATA_W-1:0] o__cons_5,
   output logic              o__sel_1,
   output logic [1:0]        o__sel_2,
   output logic              o__sel_3,
   output logic [1:0]        o__sel_4,
   output logic              o__sel_5,
   output logic [1:0]        o__sel_6,
   output logic [1:0]        o__sel_7,
   output logic [1:0]        o__sel_8,
   output logic [1:0]        o__rel_opcode,
   output logic              o__arith_opcode1,
   output logic              o__arith_opcode2,
   output logic              o__armed,
   output logic              o__cfg_err,
   output logic [GEN_W-1:0]  o__cfg_gen
`ifdef ATOM_CFG_READBACK_EN
   ,
   input  logic [2:0]        i__rd_addr,
   output logic [DATA_W-1:0] o__rd_data
`endif
);

   localparam int N_CONS = N_WORDS - 1;
   localparam int CTRL_W = 17;
   localparam logic [2:0] CTRL_ADDR = 3'(N_WORDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, ARMED} state_t;

   state_t              state;
   logic [DATA_W-1:0]   shadow_cons [N_CONS];
   logic [CTRL_W-1:0]   shadow_ctrl;
   logic [DATA_W-1:0]   active_cons [N_CONS];
   logic [CTRL_W-1:0]   active_ctrl;
   logic [N_WORDS-1:0]  mask;
   logic [N_WORDS-1:0]  wr_bit;
   logic [N_WORDS-1:0]  mask_next;
   logic                accept;
   logic                addr_ok;
   logic                mask_full;

   assign o__cfg_ready = (state != ARMED);
   assign o__armed     = (state == ARMED);

   assign accept    = i__cfg_valid && o__cfg_ready;
   assign addr_ok   = (int'(i__cfg_addr) < N_WORDS);
   assign wr_bit    = (accept && addr_ok) ? (N_WORDS'(1) << i__cfg_addr) : '0;
   // A write landing in the commit cycle itself counts toward completeness.
   assign mask_next = mask | wr_bit;
   assign mask_full = &mask_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         mask        <= '0;
         shadow_ctrl <= '0;
         active_ctrl <= '0;
         o__cfg_err  <= 1'b0;
         o__cfg_gen  <= '0;
         for (int i = 0; i < N_CONS; i++) begin
            shadow_cons[i] <= '0;
            active_cons[i] <= '0;
         end
      end else begin
         o__cfg_err <= 1'b0;
         if (accept && addr_ok) begin
            if (i__cfg_addr == CTRL_ADDR)
               shadow_ctrl <= i__cfg_data[CTRL_W-1:0];
            else
               shadow_cons[i__cfg_addr] <= i__cfg_data;
            mask <= mask_next;
         end
         if (accept && !addr_ok)
            o__cfg_err <= 1'b1;

         case (state)
            IDLE: begin
               if (accept)
                  state <= LOAD;
            end
            LOAD: begin
               if (i__commit) begin
                  if (mask_full)
                     state <= ARMED;
                  else
                     o__cfg_err <= 1'b1;
               end
            end
            ARMED: begin
               // Swap only on a bubble so no packet ever sees a half-old, half-new config.
               if (!i__pkt_valid) begin
                  active_cons <= shadow_cons;
                  active_ctrl <= shadow_ctrl;
                  mask        <= '0;
                  o__cfg_gen  <= o__cfg_gen + GEN_W'(1);
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o__cons_1        = active_cons[0];
   assign o__cons_2        = active_cons[1];
   assign o__cons_3        = active_cons[2];
   assign o__cons_4        = active_cons[3];
   assign o__cons_5        = active_cons[4];
   assign o__sel_1         = active_ctrl[0];
   assign o__sel_2         = active_ctrl[2:1];
   assign o__sel_3         = active_ctrl[3];
   assign o__sel_4         = active_ctrl[5:4];
   assign o__sel_5         = active_ctrl[6];
   assign o__sel_6         = active_ctrl[8:7];
   assign o__sel_7         = active_ctrl[10:9];
   assign o__sel_8         = active_ctrl[12:11];
   assign o__rel_opcode    = active_ctrl[14:13];
   assign o__arith_opcode1 = active_ctrl[15];
   assign o__arith_opcode2 = active_ctrl[16];

`ifdef ATOM_CFG_READBACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         o__rd_data <= '0;
      else if (int'(i__rd_addr) < N_CONS)
         o__rd_data <= active_cons[i__rd_addr];
      else if (i__rd_addr == CTRL_ADDR)
         o__rd_data <= DATA_W'(active_ctrl);
      else
         o__rd_data <= '0;
   end
`endif

endmodule

// File: tb/tb_atom_cfg_loader.sv
// Directed self-checking bench for atom_cfg_loader; readback checks only when ATOM_CFG_READBACK_EN is set.
module tb_atom_cfg_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        commit;
   logic        pkt_valid;
   logic [31:0] cons_1, cons_2, cons_3, cons_4, cons_5;
   logic        sel_1, sel_3, sel_5;
   logic [1:0]  sel_2, sel_4, sel_6, sel_7, sel_8;
   logic [1:0]  rel_opcode;
   logic        arith_opcode1, arith_opcode2;
   logic        armed;
   logic        cfg_err;
   logic [7:0]  cfg_gen;
`ifdef ATOM_CFG_READBACK_EN
   logic [2:0]  rd_addr;
   logic [31:0] rd_data;
`endif

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   atom_cfg_loader dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i__cfg_valid     (cfg_valid),
      .o__cfg_ready     (cfg_ready),
      .i__cfg_addr      (cfg_addr),
      .i__cfg_data      (cfg_data),
      .i__commit        (commit),
      .i__pkt_valid     (pkt_valid),
      .o__cons_1        (cons_1),
      .o__cons_2        (cons_2),
      .o__cons_3        (cons_3),
      .o__cons_4        (cons_4),
      .o__cons_5        (cons_5),
      .o__sel_1         (sel_1),
      .o__sel_2         (sel_2),
      .o__sel_3         (sel_3),
      .o__sel_4         (sel_4),
      .o__sel_5         (sel_5),
      .o__sel_6         (sel_6),
      .o__sel_7         (sel_7),
      .o__sel_8         (sel_8),
      .o__rel_opcode    (rel_opcode),
      .o__arith_opcode1 (arith_opcode1),
      .o__arith_opcode2 (arith_opcode2),
      .o__armed         (armed),
      .o__cfg_err       (cfg_err),
      .o__cfg_gen       (cfg_gen)
`ifdef ATOM_CFG_READBACK_EN
      ,
      .i__rd_addr       (rd_addr),
      .o__rd_data       (rd_data)
`endif
   );

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
         $error("[TB] check %s differs", tag);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
      cfg_valid = 1'b1;
      cfg_addr  = addr;
      cfg_data  = data;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic pulseCommit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_valid = 1'b0;
      cfg_addr  = '0;
      cfg_data  = '0;
      commit    = 1'b0;
      pkt_valid = 1'b0;
`ifdef ATOM_CFG_READBACK_EN
      rd_addr   = '0;
`endif

      // Reset
      repeat (3) tick();
      rst_n = 1'b1;
      checkOutput("rst_cons_1", cons_1, 32'h0);
      checkOutput("rst_cons_5", cons_5, 32'h0);
      checkOutput("rst_sel_8", {30'b0, sel_8}, 32'h0);
      checkOutput("rst_gen", {24'b0, cfg_gen}, 32'h0);
      checkOutput("rst_ready", {31'b0, cfg_ready}, 32'h1);
      checkOutput("rst_armed", {31'b0, armed}, 32'h0);
      checkOutput("rst_err", {31'b0, cfg_err}, 32'h0);

      // Full load, commit during a bubble
      for (int i = 0; i < 5; i++) applyStimulus(3'(i), 32'h11 * (i + 1));
      applyStimulus(3'd5, 32'h1FFFF);
      pulseCommit();
      checkOutput("full_armed", {31'b0, armed}, 32'h1);
      checkOutput("full_ready_low", {31'b0, cfg_ready}, 32'h0);
      checkOutput("full_not_yet", cons_1, 32'h0);
      tick();
      checkOutput("full_armed_drop", {31'b0, armed}, 32'h0);
      checkOutput("full_cons_1", cons_1, 32'h11);
      checkOutput("full_cons_5", cons_5, 32'h55);
      checkOutput("full_sel_1", {31'b0, sel_1}, 32'h1);
      checkOutput("full_sel_8", {30'b0, sel_8}, 32'h3);
      checkOutput("full_rel", {30'b0, rel_opcode}, 32'h3);
      checkOutput("full_arith2", {31'b0, arith_opcode2}, 32'h1);
      checkOutput("full_gen", {24'b0, cfg_gen}, 32'h1);

      // Bubble gating; upper control bits must be ignored
      for (int i = 0; i < 5; i++) applyStimulus(3'(i), 32'hCAFE0000 + i);
      applyStimulus(3'd5, 32'hFFFE0006);
      pkt_valid = 1'b1;
      pulseCommit();
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("gate_hold_cons_1", cons_1, 32'h11);
         checkOutput("gate_ready_low", {31'b0, cfg_ready}, 32'h0);
      end
      checkOutput("gate_armed", {31'b0, armed}, 32'h1);
      pkt_valid = 1'b0;
      tick();
      checkOutput("gate_cons_1", cons_1, 32'hCAFE0000);
      checkOutput("gate_cons_4", cons_4, 32'hCAFE0003);
      checkOutput("gate_sel_1", {31'b0, sel_1}, 32'h0);
      checkOutput("gate_sel_2", {30'b0, sel_2}, 32'h3);
      checkOutput("gate_sel_8", {30'b0, sel_8}, 32'h0);
      checkOutput("gate_arith2", {31'b0, arith_opcode2}, 32'h0);
      checkOutput("gate_gen", {24'b0, cfg_gen}, 32'h2);

      // Partial commit rejected, then completed
      for (int i = 0; i < 5; i++) applyStimulus(3'(i), 32'h100 + i);
      pulseCommit();
      checkOutput("part_err", {31'b0, cfg_err}, 32'h1);
      checkOutput("part_armed", {31'b0, armed}, 32'h0);
      checkOutput("part_ready", {31'b0, cfg_ready}, 32'h1);
      tick();
      checkOutput("part_err_clear", {31'b0, cfg_err}, 32'h0);
      checkOutput("part_gen", {24'b0, cfg_gen}, 32'h2);
      checkOutput("part_cons_hold", cons_1, 32'hCAFE0000);
      applyStimulus(3'd5, 32'h0001E000);
      pulseCommit();
      checkOutput("part_armed2", {31'b0, armed}, 32'h1);
      tick();
      checkOutput("part_cons_1", cons_1, 32'h100);
      checkOutput("part_rel", {30'b0, rel_opcode}, 32'h3);
      checkOutput("part_arith1", {31'b0, arith_opcode1}, 32'h1);
      checkOutput("part_arith2", {31'b0, arith_opcode2}, 32'h1);
      checkOutput("part_sel_2", {30'b0, sel_2}, 32'h0);
      checkOutput("part_gen2", {24'b0, cfg_gen}, 32'h3);

      // Bad address leaves the mask alone; reset while armed
      for (int i = 0; i < 5; i++) applyStimulus(3'(i), 32'h200 + i);
      applyStimulus(3'd7, 32'hDEAD);
      checkOutput("bad_err", {31'b0, cfg_err}, 32'h1);
      tick();
      checkOutput("bad_err_clear", {31'b0, cfg_err}, 32'h0);
      pulseCommit();
      checkOutput("bad_mask_incomplete", {31'b0, cfg_err}, 32'h1);
      checkOutput("bad_not_armed", {31'b0, armed}, 32'h0);
      applyStimulus(3'd5, 32'h0);
      pkt_valid = 1'b1;
      pulseCommit();
      checkOutput("rst_arm_armed", {31'b0, armed}, 32'h1);
      tick();
      checkOutput("rst_arm_hold", cons_1, 32'h100);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      pkt_valid = 1'b0;
      checkOutput("rst_arm_cons_1", cons_1, 32'h0);
      checkOutput("rst_arm_rel", {30'b0, rel_opcode}, 32'h0);
      checkOutput("rst_arm_armed", {31'b0, armed}, 32'h0);
      checkOutput("rst_arm_gen", {24'b0, cfg_gen}, 32'h0);
      checkOutput("rst_arm_ready", {31'b0, cfg_ready}, 32'h1);
      pulseCommit();
      checkOutput("idle_commit_err", {31'b0, cfg_err}, 32'h0);
      checkOutput("idle_commit_armed", {31'b0, armed}, 32'h0);
      tick();
      checkOutput("idle_commit_cons", cons_1, 32'h0);

      // Generation counter wrap
      for (int k = 0; k < 256; k++) begin
         for (int i = 0; i < 5; i++) applyStimulus(3'(i), 32'h11 * (i + 1));
         applyStimulus(3'd5, 32'h0);
         pulseCommit();
         tick();
         if (k == 254) checkOutput("wrap_gen_255", {24'b0, cfg_gen}, 32'hFF);
      end
      checkOutput("wrap_gen_0", {24'b0, cfg_gen}, 32'h0);
      checkOutput("wrap_cons_3", cons_3, 32'h33);

`ifdef ATOM_CFG_READBACK_EN
      rd_addr = 3'd2;
      tick();
      checkOutput("rd_addr2", rd_data, 32'h33);
      rd_addr = 3'd4;
      tick();
      checkOutput("rd_addr4", rd_data, 32'h55);
      rd_addr = 3'd7;
      tick();
      checkOutput("rd_addr7", rd_data, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
